// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and magnitude helper for the
//    sequential divider family (signed DIV now, unsigned DIVU later).
// Contents: div_state_t enum, DIV_WIDTH default, abs_val() magnitude function.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   // abs_val works on a sign-extended copy of the operand, so any operand
   // width up to ABS_W bits can share it; callers size-cast the result back.
   localparam int ABS_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } div_state_t;

   // Unsigned magnitude. The most negative value maps onto itself once the
   // caller truncates back to the operand width (|0x80000000| = 0x80000000).
   function automatic logic [ABS_W-1:0] abs_val(input logic signed [ABS_W-1:0] v);
      return v[ABS_W-1] ? -v : v;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division step on unsigned magnitudes.
//    Purely combinational (zero latency); no flow control.
// Ports: rem_i/q_i current partial remainder and quotient, dvs_i |divisor|;
//    rem_o/q_o the values after shifting {rem,q} left and one trial subtract.
module div_restore_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   // rem_i < dvs_i always holds, so the shifted remainder fits in WIDTH+1
   // bits and the top bit of the trial difference is a reliable sign.
   assign rem_sh = {rem_i, q_i[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, dvs_i};

   assign rem_o = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   assign q_o   = {q_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multicycle signed divider (MIPS DIV semantics), one bit per clock.
//    Latency: done pulses WIDTH+2 cycles after the start cycle; divide-by-zero answers next cycle.
//    No backpressure: start is taken only in IDLE, ignored otherwise; abort cancels with no result.
// Ports: clk/rst (sync, active-high), start, abort, dividend, divisor in;
//    quotient (to Lo), remainder (to Hi), busy, done, div_zero out.
module seq_signed_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,   // 2..ABS_W
   parameter int CNT_W = 6            // 2**CNT_W > WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   div_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] wq_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] wq_d;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic             sign_q_q;
   logic             sign_r_q;
   logic             busy_q;
   logic             done_q;
   logic             div_zero_q;

   assign dvd_mag = WIDTH'(abs_val(ABS_W'($signed(dividend))));
   assign dvs_mag = WIDTH'(abs_val(ABS_W'($signed(divisor))));

   div_restore_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i (rem_q),
      .q_i   (wq_q),
      .dvs_i (dvs_q),
      .rem_o (rem_d),
      .q_o   (wq_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         wq_q        <= '0;
         dvs_q       <= '0;
         sign_q_q    <= 1'b0;
         sign_r_q    <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else if (abort) begin
         // Results are left untouched, even if FIX was about to write them.
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q     <= 1'b0;
               div_zero_q <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     div_zero_q <= 1'b1;
                  end else begin
                     state_q  <= CALC;
                     busy_q   <= 1'b1;
                     wq_q     <= dvd_mag;
                     rem_q    <= '0;
                     dvs_q    <= dvs_mag;
                     sign_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     sign_r_q <= dividend[WIDTH-1];
                     cnt_q    <= CNT_W'(WIDTH);
                  end
               end
            end
            CALC: begin
               rem_q <= rem_d;
               wq_q  <= wq_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quotient_q  <= sign_q_q ? -wq_q : wq_q;
               remainder_q <= sign_r_q ? -rem_q : rem_q;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               done_q     <= 1'b0;
               div_zero_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed and random divisions against a plain-arithmetic model.
//    Latency and busy window are checked per operation; abort/reset/ignored-start corner cases.
//    Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_signed_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_zero;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [W-1:0] exp_q = '0;
   logic [W-1:0] exp_r = '0;

   always #5 clk = ~clk;

   seq_signed_divider #(
      .WIDTH (W),
      .CNT_W (6)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // MIPS DIV: truncate toward zero, remainder follows the dividend's sign.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
   endfunction

   // kind: 0 plain, 1 extra start at cycle 10, 2 abort at cycle 15, 3 reset at cycle 15
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int kind, input string tag);
      int           done_cyc;
      int           busy_cnt;
      int           limit;
      logic [W-1:0] q_at;
      logic [W-1:0] r_at;
      logic         dz_at;
      logic [W-1:0] mq;
      logic [W-1:0] mr;
      @(negedge clk);
      chk({tag, "/done_low_before"}, done, 0);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      done_cyc = -1;
      busy_cnt = 0;
      q_at     = '0;
      r_at     = '0;
      dz_at    = 1'b0;
      limit    = (kind >= 2) ? 50 : 60;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start    = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
         end
         if (busy) busy_cnt++;
         if (done && done_cyc < 0) begin
            done_cyc = c;
            q_at     = quotient;
            r_at     = remainder;
            dz_at    = div_zero;
         end
         if (kind == 1 && c == 10) begin
            start    = 1'b1;
            dividend = 9;
            divisor  = 3;
         end
         if (kind == 1 && c == 11) start = 1'b0;
         if (kind == 2 && c == 15) abort = 1'b1;
         if (kind == 2 && c == 16) begin
            abort = 1'b0;
            chk({tag, "/busy_after_abort"}, busy, 0);
         end
         if (kind == 3 && c == 15) rst = 1'b1;
         if (kind == 3 && c == 16) begin
            rst = 1'b0;
            chk({tag, "/rst_q"}, quotient, 0);
            chk({tag, "/rst_r"}, remainder, 0);
            chk({tag, "/rst_busy"}, busy, 0);
            chk({tag, "/rst_done"}, done, 0);
            chk({tag, "/rst_dz"}, div_zero, 0);
         end
         if (kind < 2 && done_cyc > 0) break;
      end
      if (kind < 2) begin
         if (b == '0) begin
            chk({tag, "/done_cycle"}, done_cyc, 1);
            chk({tag, "/busy_cycles"}, busy_cnt, 0);
            chk({tag, "/div_zero"}, dz_at, 1);
         end else begin
            model(a, b, mq, mr);
            exp_q = mq;
            exp_r = mr;
            chk({tag, "/done_cycle"}, done_cyc, W + 2);
            chk({tag, "/busy_cycles"}, busy_cnt, W + 1);
            chk({tag, "/div_zero"}, dz_at, 0);
         end
         chk({tag, "/quotient"}, q_at, exp_q);
         chk({tag, "/remainder"}, r_at, exp_r);
      end else begin
         if (kind == 3) begin
            exp_q = '0;
            exp_r = '0;
         end
         chk({tag, "/no_done"}, (done_cyc >= 0), 0);
         chk({tag, "/busy_end"}, busy, 0);
         chk({tag, "/quotient_kept"}, quotient, exp_q);
         chk({tag, "/remainder_kept"}, remainder, exp_r);
      end
   endtask

   initial begin
      logic         seen;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           sel;

      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      chk("reset/quotient", quotient, 0);
      chk("reset/remainder", remainder, 0);
      chk("reset/busy", busy, 0);
      chk("reset/done", done, 0);
      chk("reset/div_zero", div_zero, 0);
      rst = 1'b0;

      run_div(32'd7, 32'd2, 0, "7/2");
      run_div(32'hFFFF_FFF9, 32'd2, 0, "-7/2");
      run_div(32'd7, 32'hFFFF_FFFE, 0, "7/-2");
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, "min/-1");
      run_div(32'd7, 32'd2, 0, "7/2_again");
      run_div(32'd5, 32'd0, 0, "5/0");
      run_div(32'd100, 32'd7, 1, "100/7_extra_start");
      run_div(32'd9, 32'd3, 0, "9/3_back_to_back");
      run_div(32'd100, 32'd7, 2, "100/7_abort");
      run_div(32'd100, 32'd7, 3, "100/7_reset");
      run_div(32'd0, 32'hFFFF_FFF3, 0, "0/-13");
      run_div(32'hFFFF_FFFB, 32'd100, 0, "-5/100");
      run_div(32'h8000_0000, 32'd1, 0, "min/1");

      // start together with abort in IDLE must not launch anything
      @(negedge clk);
      dividend = 40;
      divisor  = 5;
      start    = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort/busy", busy, 0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("start_abort/activity", seen, 0);

      for (int i = 0; i < 20; i++) begin
         sel = $urandom_range(0, 9);
         ra  = $urandom;
         if (sel == 1) ra = 32'h8000_0000;
         if (sel == 2) ra = $urandom_range(0, 50);
         if (sel == 0) rb = '0;
         else if (sel <= 3) rb = $urandom_range(1, 20);
         else if (sel == 4) rb = 32'hFFFF_FFFF;
         else if (sel == 5) rb = -($urandom_range(1, 1000));
         else rb = $urandom;
         if (sel > 0 && rb == '0) rb = 32'd3;
         run_div(ra, rb, 0, "random");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Multicycle signed divider for the MIPS-subset CPU's DIV instruction; restoring algorithm, one quotient bit per clock.
- Sits directly upstream of the Hi/Lo register pair.
  - Takes operands from the A/B registers, selected by the DivOrM mux.
  - Produces remainder (to Hi) and quotient (to Lo) through the HiLoSrc mux.
- The controller starts it, waits for done, then asserts HiLoWrite.
- Flags divide-by-zero so the controller can take the exception path.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin a division; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE with no result.
- dividend  input  WIDTH  signed dividend, from A register.
- divisor  input  WIDTH  signed divisor, from B register.
- quotient  output  WIDTH  signed quotient, to Lo mux.
- remainder  output  WIDTH  signed remainder, to Hi mux.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid.
- div_zero  output  1  one-cycle pulse; divisor was zero.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - quotient=0, remainder=0, busy=0, done=0, div_zero=0.
  - Counter and internal registers cleared.
  - Reset takes priority over abort, which takes priority over everything else.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - busy=0.
  - start=1 and divisor!=0 → CALC.
    - Latch |dividend| into the working quotient register.
    - Clear the partial remainder.
    - Latch |divisor|.
    - Latch sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
    - counter = WIDTH.
  - start=1 and divisor==0 → DONE.
    - At the same edge, set div_zero=1 and done=1 for the following cycle.
    - quotient/remainder keep their previous values.
  - start=0 → stay in IDLE.
- CALC:
  - busy=1.
  - Each edge performs one restoring step:
    - Shift {rem, q} left by 1.
    - trial = rem - |divisor|, computed at WIDTH+1 bits.
    - If trial >= 0: rem = trial and q[0] = 1; otherwise q[0] = 0.
    - Decrement the counter.
  - When the counter reaches 1 at an edge, that step is the last one → FIX.
- FIX:
  - busy=1.
  - Single edge:
    - quotient = sign_q ? -q : q.
    - remainder = sign_r ? -rem : rem.
  - → DONE.
- DONE:
  - busy=0, done=1 (and div_zero, if set) for exactly one cycle.
  - → IDLE unconditionally.
  - quotient/remainder hold until the next FIX or reset.
- Latency:
  - start sampled at edge k (IDLE) → CALC steps on edges k+1..k+WIDTH → FIX at edge k+WIDTH+1.
  - done is high during the cycle after edge k+WIDTH+1: WIDTH+2 cycles after the start cycle (34 for WIDTH=32).
  - Divide-by-zero: done/div_zero high during the cycle after edge k.
- Arithmetic:
  - Results follow MIPS semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Magnitudes are computed as unsigned WIDTH-bit values, so |0x80000000| = 0x80000000.
  - 0x80000000 / -1 gives quotient 0x80000000 and remainder 0; no overflow flag.
- Boundaries:
  - start while busy (CALC/FIX) or in DONE: ignored; operand changes mid-operation are ignored.
  - abort in CALC/FIX/DONE → IDLE next edge.
    - busy=0; no done is issued.
    - quotient/remainder unchanged, including during FIX.
  - Simultaneous start and abort in IDLE: abort wins; stay in IDLE.
  - Dividend 0: quotient=0, remainder=0, full latency.
  - |dividend| < |divisor|: quotient=0, remainder=dividend.
  - Back-to-back: a start in the IDLE cycle right after DONE is accepted.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE=2'b00, CALC=2'b01, FIX=2'b10, DONE=2'b11);
  - the default WIDTH constant;
  - a function abs_val(WIDTH-bit) returning the unsigned magnitude.
- One combinational sub-module, div_restore_step.
  - Inputs: rem, q, |divisor|.
  - Outputs: next rem, next q.
  - Reusable by a later DIVU variant.
- FSM, counter and sign fixup stay in the top module.

Test Plan:
- dividend=7, divisor=2, start pulse → done at cycle 34; quotient=3, remainder=1; busy high cycles 1–33.
- dividend=-7 (0xFFFFFFF9), divisor=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Then dividend=7, divisor=-2 → quotient=-3, remainder=1.
- dividend=0x80000000, divisor=0xFFFFFFFF → quotient=0x80000000, remainder=0; div_zero=0.
- divisor=0, dividend=5, with previous quotient=3 → cycle 1: done=1 and div_zero=1 for one cycle; quotient=3 unchanged; busy never high.
- Start 100/7, then pulse start with 9/3 at cycle 10 → second start ignored; result quotient=14, remainder=2. Immediate restart with 9/3 → quotient=3, remainder=0.
- Start 100/7, then at cycle 15 in separate runs: assert abort → IDLE, no done, outputs unchanged; assert rst → all outputs 0 next cycle, state IDLE.
